vminmax_reduce_seq: RTL and testbench

- Sequencer for the vredmin/vredmax/vredminu/vredmaxu vector reductions.
- Accepts a reduction command, then streams 64-bit source beats through a lane-wise packed min/max compare. The compare is an 8/16/32/64-bit SIMD selector, as in the vALU.
- Folds the accumulated word horizontally, combines the result with the scalar seed, and returns one scalar result.
- Sits between the vALU issue logic and the min/max datapath.

---
 rtl/vminmax_reduce_seq.sv | 201 ++++++++++++++++++++
 tb/tb_vminmax_reduce_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vminmax_reduce_seq.sv
// Sequencer for the vredmin/vredmax(u) reductions. Streams 64-bit beats through a packed
// SIMD min/max, folds the accumulator down to one element and merges the scalar seed.
module vminmax_reduce_seq #(
   parameter int DATA_WIDTH = 64,
   parameter int SEW_WIDTH  = 2,
   parameter int MASK_WIDTH = 8,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic [SEW_WIDTH-1:0]  start_sew,
   input  logic [1:0]            start_op,
   input  logic [LEN_WIDTH-1:0]  start_beats,
   input  logic [DATA_WIDTH-1:0] start_init,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [MASK_WIDTH-1:0] in_mask,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy,
   output logic [2:0]            dbg_state
);

   // Every port pair is valid/ready: a transfer happens on a clock edge where both are high.
   typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_FOLD, S_FINAL, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [SEW_WIDTH-1:0]    sew_q, sew_d;
   logic [1:0]              op_q, op_d;
   logic [LEN_WIDTH-1:0]    beats_q, beats_d;
   logic [LEN_WIDTH-1:0]    cnt_q, cnt_d, cnt_inc;
   logic [DATA_WIDTH-1:0]   init_q, init_d;
   logic [DATA_WIDTH-1:0]   acc_q, acc_d;
   logic [1:0]              fold_q, fold_d;
   logic [DATA_WIDTH-1:0]   elem_m, beat_m, fold_hi;

   function automatic logic [63:0] lane_msb(input logic [1:0] sew);
      case (sew)
         2'd0:    lane_msb = 64'h8080_8080_8080_8080;
         2'd1:    lane_msb = 64'h8000_8000_8000_8000;
         2'd2:    lane_msb = 64'h8000_0000_8000_0000;
         default: lane_msb = 64'h8000_0000_0000_0000;
      endcase
   endfunction

   // Neutral element of the reduction, replicated in every lane.
   function automatic logic [63:0] ident(input logic [1:0] sew, input logic [1:0] op);
      case (op)
         2'b00:   ident = '1;
         2'b01:   ident = '0;
         2'b10:   ident = ~lane_msb(sew);
         default: ident = lane_msb(sew);
      endcase
   endfunction

   function automatic logic [63:0] width_mask(input logic [1:0] sew);
      case (sew)
         2'd0:    width_mask = 64'h0000_0000_0000_00FF;
         2'd1:    width_mask = 64'h0000_0000_0000_FFFF;
         2'd2:    width_mask = 64'h0000_0000_FFFF_FFFF;
         default: width_mask = '1;
      endcase
   endfunction

   function automatic logic [63:0] elem_mask(input logic [7:0] mask, input logic [1:0] sew);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) begin
         m[8*i +: 8] = {8{mask[3'(i >> sew)]}};
      end
      return m;
   endfunction

   // Flipping each lane MSB turns a signed compare into an unsigned one.
   function automatic logic [63:0] simd_sel(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] sew, input logic [1:0] op);
      logic [63:0] ax, bx, r;
      ax = op[1] ? (a ^ lane_msb(sew)) : a;
      bx = op[1] ? (b ^ lane_msb(sew)) : b;
      r  = '0;
      case (sew)
         2'd0: for (int i = 0; i < 8; i++)
            r[8*i +: 8] = ((ax[8*i +: 8] > bx[8*i +: 8]) == op[0]) ? a[8*i +: 8] : b[8*i +: 8];
         2'd1: for (int i = 0; i < 4; i++)
            r[16*i +: 16] = ((ax[16*i +: 16] > bx[16*i +: 16]) == op[0]) ? a[16*i +: 16] : b[16*i +: 16];
         2'd2: for (int i = 0; i < 2; i++)
            r[32*i +: 32] = ((ax[32*i +: 32] > bx[32*i +: 32]) == op[0]) ? a[32*i +: 32] : b[32*i +: 32];
         default: r = ((ax > bx) == op[0]) ? a : b;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sew_q   <= '0;
         op_q    <= '0;
         beats_q <= '0;
         cnt_q   <= '0;
         init_q  <= '0;
         acc_q   <= '0;
         fold_q  <= '0;
      end else begin
         sew_q   <= sew_d;
         op_q    <= op_d;
         beats_q <= beats_d;
         cnt_q   <= cnt_d;
         init_q  <= init_d;
         acc_q   <= acc_d;
         fold_q  <= fold_d;
      end
   end

   assign cnt_inc = cnt_q + LEN_WIDTH'(1);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:
            if (start_valid) begin
               if (start_beats != '0)      state_d = S_ACCUM;
               else if (start_sew == 2'd3) state_d = S_FINAL;
               else                        state_d = S_FOLD;
            end
         S_ACCUM:
            if (in_valid && (cnt_inc == beats_q))
               state_d = (sew_q == 2'd3) ? S_FINAL : S_FOLD;
         S_FOLD:
            if (fold_q == (2'd2 - sew_q)) state_d = S_FINAL;
         S_FINAL: state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Upper half of the live width, moved down onto the lower half for the next fold step.
   always_comb begin
      case (fold_q)
         2'd0:    fold_hi = acc_q >> 32;
         2'd1:    fold_hi = acc_q >> 16;
         default: fold_hi = acc_q >> 8;
      endcase
   end

   assign elem_m = elem_mask(in_mask, sew_q);
   assign beat_m = (in_data & elem_m) | (ident(sew_q, op_q) & ~elem_m);

   always_comb begin
      sew_d   = sew_q;
      op_d    = op_q;
      beats_d = beats_q;
      cnt_d   = cnt_q;
      init_d  = init_q;
      acc_d   = acc_q;
      fold_d  = fold_q;
      case (state_q)
         S_IDLE:
            if (start_valid) begin
               sew_d   = start_sew;
               op_d    = start_op;
               beats_d = start_beats;
               init_d  = start_init;
               acc_d   = ident(start_sew, start_op);
               cnt_d   = '0;
               fold_d  = '0;
            end
         S_ACCUM:
            if (in_valid) begin
               acc_d = simd_sel(acc_q, beat_m, sew_q, op_q);
               cnt_d = cnt_inc;
            end
         S_FOLD: begin
            acc_d  = simd_sel(acc_q, fold_hi, sew_q, op_q);
            fold_d = fold_q + 2'd1;
         end
         S_FINAL: acc_d = simd_sel(acc_q, init_q, sew_q, op_q);
         default: ;
      endcase
   end

   always_comb begin
      start_ready = (state_q == S_IDLE);
      in_ready    = (state_q == S_ACCUM);
      out_valid   = (state_q == S_DONE);
      busy        = (state_q != S_IDLE);
      out_data    = (state_q == S_DONE) ? (acc_q & width_mask(sew_q)) : '0;
      dbg_state   = state_q;
   end

endmodule

// File: tb/tb_vminmax_reduce_seq.sv
// Directed bench for vminmax_reduce_seq: a vector table with hand-computed results plus
// sequences for stalls, result back-pressure, reset mid-command and early out_ready.
module tb_vminmax_reduce_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_valid, start_ready;
   logic [1:0]  start_sew, start_op;
   logic [15:0] start_beats;
   logic [63:0] start_init;
   logic        in_valid, in_ready;
   logic [63:0] in_data;
   logic [7:0]  in_mask;
   logic        out_valid, out_ready;
   logic [63:0] out_data;
   logic        busy;
   logic [2:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [1:0]       sew;
      logic [1:0]       op;
      int               beats;
      logic [2:0][63:0] data;
      logic [2:0][7:0]  mask;
      logic [63:0]      init;
      logic [63:0]      exp;
   } vec_t;

   vec_t vecs[12];

   vminmax_reduce_seq dut (
      .clk(clk), .rst_n(rst_n),
      .start_valid(start_valid), .start_ready(start_ready), .start_sew(start_sew),
      .start_op(start_op), .start_beats(start_beats), .start_init(start_init),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mask(in_mask),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] sew, input logic [1:0] op, input int beats,
                               input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                               input logic [7:0] m0, input logic [7:0] m1, input logic [7:0] m2,
                               input logic [63:0] init, input logic [63:0] exp);
      vec_t v;
      v.sew = sew; v.op = op; v.beats = beats;
      v.data = {d2, d1, d0};
      v.mask = {m2, m1, m0};
      v.init = init; v.exp = exp;
      return v;
   endfunction

   // All driver tasks start and end one time unit after a rising edge.
   task automatic send_start(input logic [1:0] sew, input logic [1:0] op,
                             input logic [15:0] beats, input logic [63:0] init);
      start_valid = 1'b1; start_sew = sew; start_op = op;
      start_beats = beats; start_init = init;
      check("start_ready_idle", start_ready, 1'b1);
      @(posedge clk); #1;
      start_valid = 1'b0;
   endtask

   task automatic wait_out(input int first_cyc, output int cyc, output int rdy_seen);
      cyc = first_cyc;
      rdy_seen = 0;
      while (!out_valid && cyc < 100) begin
         if (in_ready) rdy_seen++;
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int cyc, rdy_seen;
      send_start(v.sew, v.op, 16'(v.beats), v.init);
      for (int b = 0; b < v.beats; b++) begin
         in_valid = 1'b1; in_data = v.data[b]; in_mask = v.mask[b];
         check($sformatf("v%0d_in_ready_b%0d", idx, b), in_ready, 1'b1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      wait_out(1 + v.beats, cyc, rdy_seen);
      check($sformatf("v%0d_latency", idx), 64'(cyc), 64'(v.beats + 5 - int'(v.sew)));
      check($sformatf("v%0d_no_in_ready_after_beats", idx), 64'(rdy_seen), 64'd0);
      check($sformatf("v%0d_out_data", idx), out_data, v.exp);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check($sformatf("v%0d_out_valid_fall", idx), out_valid, 1'b0);
      check($sformatf("v%0d_start_ready_again", idx), start_ready, 1'b1);
   endtask

   initial begin
      int cyc, rdy_seen;
      logic [2:0][63:0] seq_data;

      vecs[0]  = mk(2'd0, 2'b01, 1, 64'h0807060504030201, 64'h0, 64'h0, 8'hFF, 8'h00, 8'h00, 64'h05, 64'h08);
      vecs[1]  = mk(2'd0, 2'b10, 2, 64'h7F00000000000000, 64'h80, 64'h0, 8'hFF, 8'hFF, 8'h00, 64'h10, 64'h80);
      vecs[2]  = mk(2'd2, 2'b00, 1, 64'h0000000300000002, 64'h0, 64'h0, 8'h00, 8'h00, 8'h00, 64'h9, 64'h9);
      vecs[3]  = mk(2'd3, 2'b11, 0, 64'h0, 64'h0, 64'h0, 8'h00, 8'h00, 8'h00,
                    64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE);
      vecs[4]  = mk(2'd1, 2'b11, 1, 64'h8000_7FFF_0001_FFFF, 64'h0, 64'h0, 8'h0F, 8'h00, 8'h00, 64'h0, 64'h7FFF);
      vecs[5]  = mk(2'd2, 2'b10, 2, 64'h00000005_FFFFFFF0, 64'h80000000_00000001, 64'h0,
                    8'h01, 8'h01, 8'h00, 64'h3, 64'hFFFF_FFF0);
      vecs[6]  = mk(2'd3, 2'b00, 3, 64'h10, 64'h05, 64'h20, 8'h01, 8'h00, 8'h01, 64'h100, 64'h10);
      vecs[7]  = mk(2'd0, 2'b00, 1, 64'h0102030405060708, 64'h0, 64'h0, 8'hF0, 8'h00, 8'h00, 64'h03, 64'h01);
      vecs[8]  = mk(2'd1, 2'b00, 0, 64'h0, 64'h0, 64'h0, 8'h00, 8'h00, 8'h00,
                    64'hFFFF_FFFF_FFFF_1234, 64'h1234);
      vecs[9]  = mk(2'd2, 2'b01, 1, 64'hFFFFFFFF_00000001, 64'h0, 64'h0, 8'h03, 8'h00, 8'h00, 64'h2, 64'hFFFF_FFFF);
      vecs[10] = mk(2'd0, 2'b00, 2, 64'h7F00000000000000, 64'h80, 64'h0, 8'hFF, 8'hFF, 8'h00, 64'h10, 64'h00);
      vecs[11] = mk(2'd0, 2'b11, 1, 64'h81FE7F0280C0E010, 64'h0, 64'h0, 8'hFF, 8'h00, 8'h00, 64'hF0, 64'h7F);

      // clock/reset block
      rst_n = 1'b0; start_valid = 1'b0; start_sew = '0; start_op = '0; start_beats = '0;
      start_init = '0; in_valid = 1'b0; in_data = '0; in_mask = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_start_ready", start_ready, 1'b1);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_out_data", out_data, 64'h0);
      check("rst_state", dbg_state, 3'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

      // sew=16 umax with input gaps, a rejected start while busy and a held result
      seq_data = {64'h0001_0000_0000_0000, 64'h0000_0000_BEEF_0000, 64'h0000_0000_0001_1234};
      send_start(2'd1, 2'b01, 16'd3, 64'h0);
      for (int b = 0; b < 3; b++) begin
         in_valid = 1'b1; in_data = seq_data[b]; in_mask = 8'h0F;
         @(posedge clk); #1;
         in_valid = 1'b0;
         start_valid = 1'b1; start_sew = 2'd3; start_op = 2'b00; start_beats = 16'd0;
         start_init = 64'h0;
         check("gap_start_ready_busy", start_ready, 1'b0);
         if (b < 2) check("gap_state_accum", dbg_state, 3'd1);
         @(posedge clk); #1;
         start_valid = 1'b0;
         @(posedge clk); #1;
      end
      wait_out(0, cyc, rdy_seen);
      check("gap_out_valid_seen", out_valid, 1'b1);
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         check("gap_hold_in_ready_low", in_ready, 1'b0);
         check("gap_hold_out_valid", out_valid, 1'b1);
         check("gap_hold_out_data", out_data, 64'hBEEF);
         check("gap_hold_state_done", dbg_state, 3'd4);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("gap_out_valid_fall", out_valid, 1'b0);
      check("gap_busy_fall", busy, 1'b0);

      // reset during ACCUM abandons the command
      send_start(2'd0, 2'b01, 16'd4, 64'h0);
      for (int b = 0; b < 2; b++) begin
         in_valid = 1'b1; in_data = '1; in_mask = 8'hFF;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrst_state_idle", dbg_state, 3'd0);
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_start_ready", start_ready, 1'b1);
      repeat (6) begin
         check("midrst_no_result", out_valid, 1'b0);
         @(posedge clk); #1;
      end
      run_vec(mk(2'd0, 2'b01, 1, 64'h0102030405060708, 64'h0, 64'h0, 8'hFF, 8'h00, 8'h00,
                 64'h0, 64'h08), 100);

      // out_ready high before DONE: single-cycle result
      out_ready = 1'b1;
      send_start(2'd3, 2'b01, 16'd0, 64'h42);
      wait_out(1, cyc, rdy_seen);
      check("early_ready_latency", 64'(cyc), 64'd2);
      check("early_ready_out_data", out_data, 64'h42);
      @(posedge clk); #1;
      check("early_ready_out_valid_fall", out_valid, 1'b0);
      check("early_ready_state_idle", dbg_state, 3'd0);
      out_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
